// File: rtl/apb_gpo_port_if.sv
// APB (AMBA3-style) bus bundle for the GPO port.
// master modport: bridge side, drives address/control/write data.
// slave modport : peripheral side, returns PRDATA and PREADY.
interface apb_gpo_port_if;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_gpo_port.sv
// APB slave with a NUM_PINS-wide general-purpose output port and per-pin enable.
// Ports:
//   PCLK    - clock, all state updates on the rising edge
//   PRESET  - synchronous active-high reset, clears MODER and ODR
//   apb     - APB slave bus (PADDR/PWRITE/PSEL/PENABLE/PWDATA in, PRDATA/PREADY out)
//   gpo     - tri-state pins: gpo[i] = MODER[i] ? ODR[i] : Z
// Register map (PADDR[3:2]): 0 MODER, 1 ODR, 2 ODR_SET (WO), 3 ODR_CLR (WO).
module apb_gpo_port #(
    parameter int unsigned NUM_PINS = 4
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_gpo_port_if.slave       apb,
    output tri [NUM_PINS-1:0]   gpo
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SEL_MODER   = 2'd0;
    localparam logic [1:0] SEL_ODR     = 2'd1;
    localparam logic [1:0] SEL_ODR_SET = 2'd2;
    localparam logic [1:0] SEL_ODR_CLR = 2'd3;

    logic [NUM_PINS-1:0] r_moder;
    logic [NUM_PINS-1:0] r_odr;

    logic                w_wr_en;
    logic [1:0]          w_sel;
    logic [NUM_PINS-1:0] w_wdata;
    logic                w_unused;

    // Zero-wait-state access: a write commits on every edge of the access phase.
    assign w_wr_en  = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_sel    = apb.PADDR[3:2];
    assign w_wdata  = apb.PWDATA[NUM_PINS-1:0];
    assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA[DATA_W-1:NUM_PINS]};

    assign apb.PREADY = apb.PSEL & apb.PENABLE;

    // Register file; reset wins over a same-cycle write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_moder <= '0;
            r_odr   <= '0;
        end else if (w_wr_en) begin
            case (w_sel)
                SEL_MODER:   r_moder <= w_wdata;
                SEL_ODR:     r_odr   <= w_wdata;
                SEL_ODR_SET: r_odr   <= r_odr | w_wdata;
                SEL_ODR_CLR: r_odr   <= r_odr & ~w_wdata;
                default:     r_odr   <= r_odr;
            endcase
        end
    end

    // Read mux; write-only registers and idle bus return zero.
    always_comb begin
        apb.PRDATA = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (w_sel)
                SEL_MODER: apb.PRDATA = DATA_W'(r_moder);
                SEL_ODR:   apb.PRDATA = DATA_W'(r_odr);
                default:   apb.PRDATA = '0;
            endcase
        end
    end

    // Per-pin tri-state driver.
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        assign gpo[gi] = r_moder[gi] ? r_odr[gi] : 1'bz;
    end
endmodule

// File: tb/tb_apb_gpo_port.sv
// Self-checking bench for apb_gpo_port. Two identical DUTs share the stimulus;
// one pin bus is pulled up and the other pulled down, so a released pin reads
// 1 on the first and 0 on the second, while a driven pin reads the same on both.
module tb_apb_gpo_port;
    localparam int unsigned NP = 4;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_gpo_port_if apb_pu ();
    apb_gpo_port_if apb_pd ();

    tri1 [NP-1:0] gpo_pu;
    tri0 [NP-1:0] gpo_pd;

    apb_gpo_port #(.NUM_PINS(NP)) u_dut_pu (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (apb_pu),
        .gpo    (gpo_pu)
    );

    apb_gpo_port #(.NUM_PINS(NP)) u_dut_pd (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (apb_pd),
        .gpo    (gpo_pd)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NP-1:0] m_moder;
    logic [NP-1:0] m_odr;

    logic [31:0] rd_q[$];
    logic [31:0] pin_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic en, input logic wr,
                         input logic [3:0] addr, input logic [31:0] data);
        apb_pu.PSEL = sel;  apb_pu.PENABLE = en;  apb_pu.PWRITE = wr;
        apb_pu.PADDR = addr; apb_pu.PWDATA = data;
        apb_pd.PSEL = sel;  apb_pd.PENABLE = en;  apb_pd.PWRITE = wr;
        apb_pd.PADDR = addr; apb_pd.PWDATA = data;
    endtask

    // Expected pins packed as {pull-up view, pull-down view}.
    function automatic logic [31:0] exp_pins();
        logic [NP-1:0] drv;
        drv = m_moder & m_odr;
        return 32'({drv | ~m_moder, drv});
    endfunction

    task automatic push_pins();
        pin_q.push_back(exp_pins());
    endtask

    task automatic pop_pins(input string tag);
        logic [31:0] e;
        e = pin_q.pop_front();
        check(tag, 32'({gpo_pu, gpo_pd}), e);
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data);
        case (addr[3:2])
            2'd0: m_moder = data[NP-1:0];
            2'd1: m_odr   = data[NP-1:0];
            2'd2: m_odr   = m_odr | data[NP-1:0];
            default: m_odr = m_odr & ~data[NP-1:0];
        endcase
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        drive(1'b1, 1'b0, 1'b1, addr, data);
        @(negedge PCLK);
        drive(1'b1, 1'b1, 1'b1, addr, data);
        #1 check("wr_pready", 32'(apb_pu.PREADY), 32'd1);
        @(posedge PCLK);
        model_write(addr, data);
        push_pins();
        @(negedge PCLK);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1 pop_pins("pins");
    endtask

    task automatic apb_read(input logic [3:0] addr);
        logic [31:0] e;
        @(negedge PCLK);
        drive(1'b1, 1'b0, 1'b0, addr, 32'h0);
        #1 check("setup_pready", 32'(apb_pu.PREADY), 32'd0);
        @(negedge PCLK);
        drive(1'b1, 1'b1, 1'b0, addr, 32'h0);
        case (addr[3:2])
            2'd0:    rd_q.push_back(32'(m_moder));
            2'd1:    rd_q.push_back(32'(m_odr));
            default: rd_q.push_back(32'h0);
        endcase
        #1;
        check("rd_pready", 32'(apb_pu.PREADY), 32'd1);
        e = rd_q.pop_front();
        check("rd_pu", apb_pu.PRDATA, e);
        check("rd_pd", apb_pd.PRDATA, e);
        @(negedge PCLK);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1 check("idle_prdata", apb_pu.PRDATA, 32'h0);
    endtask

    initial begin
        m_moder = '0;
        m_odr   = '0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;

        // 1: reset state
        push_pins();
        #1 pop_pins("reset_pins");
        check("reset_pins_const", 32'({gpo_pu, gpo_pd}), 32'h000000F0);
        apb_read(4'h0);
        apb_read(4'h4);
        @(negedge PCLK);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        #1 check("nosel_pready", 32'(apb_pu.PREADY), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);

        // 2: all pins enabled, toggle data
        apb_write(4'h0, 32'h0000000F);
        apb_write(4'h4, 32'hF);
        check("all_on_const", 32'({gpo_pu, gpo_pd}), 32'h000000FF);
        apb_write(4'h4, 32'h0);
        apb_write(4'h4, 32'hF);
        apb_write(4'h4, 32'h0);

        // 3: all pins released, data still stored
        apb_write(4'h0, 32'h0);
        apb_write(4'h4, 32'hF);
        apb_write(4'h4, 32'h0);
        apb_write(4'h4, 32'hF);
        apb_write(4'h4, 32'h0);
        apb_read(4'h4);

        // 4: partial enable, reserved upper write bits ignored
        apb_write(4'h4, 32'hF);
        apb_write(4'h0, 32'h5);
        check("z1z1_const", 32'({gpo_pu, gpo_pd}), 32'h000000F5);
        apb_read(4'h0);
        apb_write(4'h0, 32'hFFFFFFF0);
        apb_read(4'h0);

        // 5: set/clear registers, write-only reads, low address bits ignored
        apb_write(4'h4, 32'h0);
        apb_write(4'h0, 32'hF);
        apb_write(4'h8, 32'h3);
        check("set_const", 32'({gpo_pu, gpo_pd}), 32'h00000033);
        apb_write(4'hC, 32'hFFFFFFF1);
        check("clr_const", 32'({gpo_pu, gpo_pd}), 32'h00000022);
        apb_read(4'h8);
        apb_read(4'hC);
        apb_read(4'h7);

        // 6: held setup phase must not commit
        @(negedge PCLK);
        drive(1'b1, 1'b0, 1'b1, 4'h4, 32'hA);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_pready", 32'(apb_pu.PREADY), 32'd0);
            @(posedge PCLK);
            push_pins();
            @(negedge PCLK);
            #1 pop_pins("hold_pins");
        end
        drive(1'b1, 1'b1, 1'b1, 4'h4, 32'hA);
        #1 check("hold_acc_pready", 32'(apb_pu.PREADY), 32'd1);
        @(posedge PCLK);
        model_write(4'h4, 32'hA);
        push_pins();
        @(negedge PCLK);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1 pop_pins("hold_commit_pins");
        apb_read(4'h4);

        // 6: reset during an access phase wins over the write
        @(negedge PCLK);
        drive(1'b1, 1'b0, 1'b1, 4'h4, 32'h5);
        @(negedge PCLK);
        drive(1'b1, 1'b1, 1'b1, 4'h4, 32'h5);
        PRESET = 1'b1;
        @(posedge PCLK);
        m_moder = '0;
        m_odr   = '0;
        push_pins();
        @(negedge PCLK);
        PRESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1 pop_pins("rst_mid_pins");
        apb_read(4'h0);
        apb_read(4'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/apb_gpo_port.md
Name: apb_gpo_port

Overview:
- APB (AMBA3-style) slave providing a 4-bit general-purpose output port with per-pin output enable.
- Software programs a mode register (pin enable) and an output data register over the APB bus.
- Each pin drives its data bit when enabled and is released to high-Z when disabled.
- Sits on the peripheral APB bus behind the bridge; `gpo` goes to chip pins or board LEDs.

Parameters:
- NUM_PINS, 4, number of output pins. Register fields use bits [NUM_PINS-1:0]; upper bits are reserved.

Ports:
- PCLK  input  1  system clock; all state updates on the rising edge.
- PRESET  input  1  reset, synchronous and active-high.
- PADDR  input  4  byte address; decode uses PADDR[3:2]; PADDR[1:0] ignored.
- PWRITE  input  1  1 = write, 0 = read.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- gpo  output (tri-state)  NUM_PINS  output pins.

Behaviour:

Reset:
- PRESET=1 at a PCLK rising edge sets MODER=0 and ODR=0.
- Consequently gpo = all Z after reset.
- Reset takes priority over any bus transfer in the same cycle.

Register map:
- 0x0 MODER: RW. Bit i=1 enables pin i as a driven output.
- 0x4 ODR: RW. Output data.
- 0x8 ODR_SET: WO. Writing 1 to bit i sets ODR[i]; 0 bits have no effect. Reads return 0.
- 0xC ODR_CLR: WO. Writing 1 to bit i clears ODR[i]; 0 bits have no effect. Reads return 0.
- Bits [31:NUM_PINS] of any write are ignored. Reads return 0 in those bits.

APB handshake:
- Setup phase: PSEL=1, PENABLE=0. No state change; PREADY=0.
- Access phase: PSEL=1, PENABLE=1. PREADY=1 combinationally in the same cycle (zero wait states).
- Write commit: on the rising edge where PSEL & PENABLE & PWRITE are all 1, the addressed register is updated from PWDATA.
- Held access phase: if PSEL and PENABLE stay high for several cycles, the write re-commits each cycle. This is harmless because every write is idempotent.
- PSEL=0: no transfer; PREADY=0 regardless of PENABLE.

Reads:
- PRDATA is combinational from PADDR[3:2] while PSEL=1 and PWRITE=0.
- MODER and ODR are returned zero-extended to 32 bits.
- PRDATA=0 at all other times.
- No side effects on read.
- No error response: PSLVERR is not implemented.

Pin output:
- gpo[i] = MODER[i] ? ODR[i] : Z, evaluated independently per pin, continuously from register state.
- A pin change is visible immediately after the committing edge.
- Changing ODR while MODER[i]=0 updates the stored value but the pin stays Z. The stored value appears as soon as MODER[i] is set.

Simultaneous events:
- Only one register can be written per transfer.
- A write to ODR_SET or ODR_CLR affects only the bits written as 1.

Test Plan:
1. Reset → gpo=4'bzzzz. Read 0x0 → PRDATA=0. Read 0x4 → PRDATA=0. PREADY=1 in each access phase.
2. Write 0x0=0x0000000F, then write 0x4=0xF → gpo=4'b1111. Then 0x4=0x0 → gpo=4'b0000. Then 0x4=0xF → 4'b1111. Then 0x4=0x0 → 4'b0000.
3. Write 0x0=0x0, then toggle 0x4 through 0xF, 0x0, 0xF, 0x0 → gpo stays 4'bzzzz throughout. A final read of 0x4 returns 0x0.
4. MODER=0x5 with ODR=0xF → gpo=4'bz1z1. Read 0x0 → 0x00000005. Write 0x0=0xFFFFFFF0 → gpo=4'bzzzz and read 0x0 → 0x0.
5. ODR=0x0 and MODER=0xF. Write 0x8=0x3 → gpo=4'b0011. Write 0xC=0x1 → gpo=4'b0010. Reads of 0x8 and 0xC → 0.
6. Hold setup phase (PSEL=1, PENABLE=0) for 3 cycles → PREADY=0 and no register change. Then assert PENABLE → PREADY=1 and the write commits. Assert PRESET mid-transfer → registers return to 0 and gpo=4'bzzzz.
